// File: rtl/ppi_port_a_strobed.sv
// Port A strobed-handshake stage (8255 mode 1, group A): pin sampling, edge detection,
// STB/IBF and ACK/OBF handshakes, interrupt request and the CPU read mux.
module ppi_port_a_strobed (
   input  logic       clk,
   input  logic       reset,
   input  logic       cs_n,
   input  logic       rd_n,
   input  logic       wr_n,
   input  logic [1:0] a,
   input  logic [7:0] bus_in,
   output logic [7:0] bus_out,
   output logic       bus_dir,
   input  logic [7:0] pa_in,
   output logic [7:0] pa_out,
   input  logic       stb_n,
   input  logic       ack_n,
   output logic       ibf,
   output logic       obf_n,
   output logic       intr
);

   // Stage s1: raw pin samples
   logic       r_cs_s1, r_rd_s1, r_wr_s1, r_stb_s1, r_ack_s1;
   logic [1:0] r_a_s1;
   logic [7:0] r_bus_s1, r_pa_s1;
   // Stage s2: previous strobe samples
   logic       r_rd_s2, r_wr_s2, r_stb_s2, r_ack_s2;
   logic       r_s1_vld, r_s2_vld;

   // Registered edge events plus the s1 context they were detected with
   logic       r_rd_fall, r_rd_rise, r_wr_fall, r_wr_rise;
   logic       r_stb_fall, r_stb_rise, r_ack_fall, r_ack_rise;
   logic       r_ev_sel;
   logic [1:0] r_ev_a;
   logic [7:0] r_ev_bus, r_ev_pa;

   // Architectural state
   logic       r_dir, r_ibf, r_obf_n, r_intr, r_inte_in, r_inte_out;
   logic [7:0] r_in_latch, r_pa_out;

   logic       w_dir_d, w_ibf_d, w_obf_n_d, w_intr_d, w_inte_in_d, w_inte_out_d;
   logic [7:0] w_in_latch_d, w_pa_out_d;
   logic       w_port, w_ctrl;
   logic       w_rd_act;
   logic [7:0] w_status;

   always_ff @(posedge clk) begin
      if (reset) begin
         r_cs_s1    <= 1'b1;
         r_rd_s1    <= 1'b1;
         r_wr_s1    <= 1'b1;
         r_stb_s1   <= 1'b1;
         r_ack_s1   <= 1'b1;
         r_a_s1     <= 2'b00;
         r_bus_s1   <= 8'h00;
         r_pa_s1    <= 8'h00;
         r_rd_s2    <= 1'b1;
         r_wr_s2    <= 1'b1;
         r_stb_s2   <= 1'b1;
         r_ack_s2   <= 1'b1;
         r_s1_vld   <= 1'b0;
         r_s2_vld   <= 1'b0;
         r_rd_fall  <= 1'b0;
         r_rd_rise  <= 1'b0;
         r_wr_fall  <= 1'b0;
         r_wr_rise  <= 1'b0;
         r_stb_fall <= 1'b0;
         r_stb_rise <= 1'b0;
         r_ack_fall <= 1'b0;
         r_ack_rise <= 1'b0;
         r_ev_sel   <= 1'b0;
         r_ev_a     <= 2'b00;
         r_ev_bus   <= 8'h00;
         r_ev_pa    <= 8'h00;
      end else begin
         r_cs_s1    <= cs_n;
         r_rd_s1    <= rd_n;
         r_wr_s1    <= wr_n;
         r_stb_s1   <= stb_n;
         r_ack_s1   <= ack_n;
         r_a_s1     <= a;
         r_bus_s1   <= bus_in;
         r_pa_s1    <= pa_in;
         r_rd_s2    <= r_rd_s1;
         r_wr_s2    <= r_wr_s1;
         r_stb_s2   <= r_stb_s1;
         r_ack_s2   <= r_ack_s1;
         r_s1_vld   <= 1'b1;
         r_s2_vld   <= r_s1_vld;
         // s2 still holding its reset value is not real history, so no edge is reported
         r_rd_fall  <= r_s2_vld &  r_rd_s2  & ~r_rd_s1;
         r_rd_rise  <= r_s2_vld & ~r_rd_s2  &  r_rd_s1;
         r_wr_fall  <= r_s2_vld &  r_wr_s2  & ~r_wr_s1;
         r_wr_rise  <= r_s2_vld & ~r_wr_s2  &  r_wr_s1;
         r_stb_fall <= r_s2_vld &  r_stb_s2 & ~r_stb_s1;
         r_stb_rise <= r_s2_vld & ~r_stb_s2 &  r_stb_s1;
         r_ack_fall <= r_s2_vld &  r_ack_s2 & ~r_ack_s1;
         r_ack_rise <= r_s2_vld & ~r_ack_s2 &  r_ack_s1;
         r_ev_sel   <= ~r_cs_s1;
         r_ev_a     <= r_a_s1;
         r_ev_bus   <= r_bus_s1;
         r_ev_pa    <= r_pa_s1;
      end
   end

   assign w_port = r_ev_sel & (r_ev_a == 2'b00);
   assign w_ctrl = r_ev_sel & (r_ev_a == 2'b11) & r_wr_rise;

   always_comb begin
      w_dir_d      = r_dir;
      w_ibf_d      = r_ibf;
      w_obf_n_d    = r_obf_n;
      w_intr_d     = r_intr;
      w_inte_in_d  = r_inte_in;
      w_inte_out_d = r_inte_out;
      w_in_latch_d = r_in_latch;
      w_pa_out_d   = r_pa_out;
      // Clears are applied first so a same-cycle set wins
      if (!r_dir) begin
         if (w_port && r_rd_rise) w_ibf_d = 1'b0;
         if (r_stb_fall) begin
            w_in_latch_d = r_ev_pa;
            w_ibf_d      = 1'b1;
         end
         if (w_port && r_rd_fall) w_intr_d = 1'b0;
         if (r_stb_rise && r_ibf && r_inte_in) w_intr_d = 1'b1;
      end else begin
         if (w_port && r_wr_fall) w_intr_d = 1'b0;
         if (r_ack_fall) w_obf_n_d = 1'b1;
         if (w_port && r_wr_rise) begin
            w_pa_out_d = r_ev_bus;
            w_obf_n_d  = 1'b0;
         end
         if (r_ack_rise && r_obf_n && r_inte_out) w_intr_d = 1'b1;
      end
      if (w_ctrl) begin
         if (r_ev_bus[7]) begin
            w_dir_d      = ~r_ev_bus[4];
            w_ibf_d      = 1'b0;
            w_intr_d     = 1'b0;
            w_inte_in_d  = 1'b0;
            w_inte_out_d = 1'b0;
            w_obf_n_d    = 1'b1;
         end else if (r_ev_bus[3:1] == 3'd4) begin
            w_inte_in_d  = r_ev_bus[0];
         end else if (r_ev_bus[3:1] == 3'd6) begin
            w_inte_out_d = r_ev_bus[0];
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_dir      <= 1'b0;
         r_ibf      <= 1'b0;
         r_obf_n    <= 1'b1;
         r_intr     <= 1'b0;
         r_inte_in  <= 1'b0;
         r_inte_out <= 1'b0;
         r_in_latch <= 8'h00;
         r_pa_out   <= 8'h00;
      end else begin
         r_dir      <= w_dir_d;
         r_ibf      <= w_ibf_d;
         r_obf_n    <= w_obf_n_d;
         r_intr     <= w_intr_d;
         r_inte_in  <= w_inte_in_d;
         r_inte_out <= w_inte_out_d;
         r_in_latch <= w_in_latch_d;
         r_pa_out   <= w_pa_out_d;
      end
   end

   assign w_rd_act = ~cs_n & ~rd_n;
   assign w_status = {2'b00, r_dir, r_inte_out, r_inte_in, r_obf_n, r_ibf, r_intr};

   always_comb begin
      bus_out = 8'h00;
      if (w_rd_act) begin
         case (a)
            2'b00:   bus_out = r_dir ? r_pa_out : r_in_latch;
            2'b10:   bus_out = w_status;
            default: bus_out = 8'h00;
         endcase
      end
   end

   assign bus_dir = w_rd_act & (a != 2'b11);
   assign pa_out  = r_pa_out;
   assign ibf     = r_ibf;
   assign obf_n   = r_obf_n;
   assign intr    = r_intr;

endmodule

// File: tb/tb_ppi_port_a_strobed.sv
// Directed bench for ppi_port_a_strobed: handshakes, priorities, ignored accesses and reset.
module tb_ppi_port_a_strobed;

   logic       clk = 1'b0;
   logic       reset, cs_n, rd_n, wr_n, stb_n, ack_n;
   logic [1:0] a;
   logic [7:0] bus_in, pa_in;
   logic [7:0] bus_out, pa_out;
   logic       bus_dir, ibf, obf_n, intr;

   int n_chk = 0;
   int n_err = 0;

   ppi_port_a_strobed dut (
      .clk     (clk),
      .reset   (reset),
      .cs_n    (cs_n),
      .rd_n    (rd_n),
      .wr_n    (wr_n),
      .a       (a),
      .bus_in  (bus_in),
      .bus_out (bus_out),
      .bus_dir (bus_dir),
      .pa_in   (pa_in),
      .pa_out  (pa_out),
      .stb_n   (stb_n),
      .ack_n   (ack_n),
      .ibf     (ibf),
      .obf_n   (obf_n),
      .intr    (intr)
   );

   always #5 clk = ~clk;

   task automatic step(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic chk8(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      n_chk++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic chk1(input string tag, input logic obs, input logic exp);
      n_chk++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %b expected %b", tag, obs, exp);
      end
   endtask

   // Full write cycle: strobe low 3 cycles, then high long enough for the update to land
   task automatic cpu_wr(input logic [1:0] addr, input logic [7:0] data);
      cs_n = 1'b0; a = addr; bus_in = data; wr_n = 1'b0;
      step(3);
      wr_n = 1'b1;
      step(3);
      cs_n = 1'b1; a = 2'b00;
      step(1);
   endtask

   // Combinational look at the read mux; the strobe is too short to be sampled
   task automatic peek(input string tag, input logic [1:0] addr, input logic [7:0] exp,
                       input logic exp_dir);
      cs_n = 1'b0; a = addr; rd_n = 1'b0;
      #1;
      chk8(tag, bus_out, exp);
      chk1({tag, "_dir"}, bus_dir, exp_dir);
      rd_n = 1'b1; cs_n = 1'b1; a = 2'b00;
      #1;
   endtask

   initial begin
      reset = 1'b1; cs_n = 1'b1; rd_n = 1'b1; wr_n = 1'b1; a = 2'b00;
      bus_in = 8'h00; pa_in = 8'h00; stb_n = 1'b0; ack_n = 1'b1;

      // Reset with stb_n held low
      step(2);
      chk1("rst_ibf", ibf, 1'b0);
      chk1("rst_obf_n", obf_n, 1'b1);
      chk1("rst_intr", intr, 1'b0);
      chk8("rst_pa_out", pa_out, 8'h00);
      chk1("rst_bus_dir", bus_dir, 1'b0);
      chk8("rst_bus_out", bus_out, 8'h00);
      reset = 1'b0;
      step(5);
      chk1("no_spurious_ibf", ibf, 1'b0);
      stb_n = 1'b1;
      step(4);
      chk1("rise_no_ibf_intr", intr, 1'b0);
      peek("rst_status", 2'b10, 8'h04, 1'b1);

      // Strobed input
      cpu_wr(2'b11, 8'h09);
      peek("inte_in_status", 2'b10, 8'h0C, 1'b1);
      pa_in = 8'hA5; stb_n = 1'b0;
      step(2);
      chk1("ibf_two_edges", ibf, 1'b0);
      step(1);
      chk1("ibf_three_edges", ibf, 1'b1);
      stb_n = 1'b1; pa_in = 8'h00;
      step(2);
      chk1("intr_two_edges", intr, 1'b0);
      step(1);
      chk1("intr_after_stb_rise", intr, 1'b1);
      cs_n = 1'b0; a = 2'b00; rd_n = 1'b0;
      #1;
      chk8("rd_pa_data", bus_out, 8'hA5);
      chk1("rd_pa_dir", bus_dir, 1'b1);
      step(3);
      chk1("intr_clr_rd_fall", intr, 1'b0);
      chk1("ibf_held_rd_low", ibf, 1'b1);
      rd_n = 1'b1;
      #1;
      chk1("rd_end_dir", bus_dir, 1'b0);
      chk8("rd_end_bus", bus_out, 8'h00);
      step(3);
      chk1("ibf_clr_rd_rise", ibf, 1'b0);
      cs_n = 1'b1;
      step(1);

      // Second stb fall coincides with the rd rise of a pending read
      pa_in = 8'h11; stb_n = 1'b0;
      step(3);
      stb_n = 1'b1;
      step(3);
      chk1("fill_intr", intr, 1'b1);
      cs_n = 1'b0; a = 2'b00; rd_n = 1'b0;
      step(3);
      chk1("fill_intr_clr", intr, 1'b0);
      pa_in = 8'h5A; stb_n = 1'b0; rd_n = 1'b1;
      step(3);
      chk1("sim_ibf_set_wins", ibf, 1'b1);
      cs_n = 1'b1;
      stb_n = 1'b1;
      step(3);
      chk1("sim_intr_reset", intr, 1'b1);
      peek("sim_latch_new", 2'b00, 8'h5A, 1'b1);

      // Control write mid-handshake
      cpu_wr(2'b11, 8'h90);
      chk1("cw_ibf", ibf, 1'b0);
      chk1("cw_intr", intr, 1'b0);
      peek("cw_status", 2'b10, 8'h04, 1'b1);
      peek("cw_latch_kept", 2'b00, 8'h5A, 1'b1);

      // Ignored accesses
      cpu_wr(2'b00, 8'h77);
      chk8("wr_in_mode_pa_out", pa_out, 8'h00);
      chk1("wr_in_mode_obf_n", obf_n, 1'b1);
      a = 2'b11; bus_in = 8'h80; wr_n = 1'b0;
      step(3);
      wr_n = 1'b1;
      step(3);
      a = 2'b00;
      peek("cs_high_ctrl", 2'b10, 8'h04, 1'b1);
      cpu_wr(2'b11, 8'h05);
      peek("bsr_bit2", 2'b10, 8'h04, 1'b1);
      peek("ctrl_read", 2'b11, 8'h00, 1'b0);
      rd_n = 1'b0; a = 2'b10;
      #1;
      chk1("cs_high_read_dir", bus_dir, 1'b0);
      chk8("cs_high_read_bus", bus_out, 8'h00);
      rd_n = 1'b1; a = 2'b00;
      step(3);

      // Strobed output
      cpu_wr(2'b11, 8'h80);
      cpu_wr(2'b11, 8'h09);
      cpu_wr(2'b11, 8'h0D);
      peek("out_status", 2'b10, 8'h3C, 1'b1);
      cpu_wr(2'b00, 8'h3C);
      chk8("out_pa_out", pa_out, 8'h3C);
      chk1("out_obf_n", obf_n, 1'b0);
      stb_n = 1'b0;
      step(3);
      stb_n = 1'b1;
      step(3);
      chk1("out_stb_ignored_ibf", ibf, 1'b0);
      chk1("out_stb_ignored_intr", intr, 1'b0);
      ack_n = 1'b0;
      step(2);
      chk1("ack_two_edges", obf_n, 1'b0);
      step(1);
      chk1("ack_obf_n", obf_n, 1'b1);
      ack_n = 1'b1;
      step(3);
      chk1("ack_intr", intr, 1'b1);
      peek("ack_status", 2'b10, 8'h3D, 1'b1);
      cs_n = 1'b0; a = 2'b00; rd_n = 1'b0;
      #1;
      chk8("out_rd_pa", bus_out, 8'h3C);
      step(3);
      rd_n = 1'b1;
      step(3);
      cs_n = 1'b1;
      chk1("out_rd_no_flags_intr", intr, 1'b1);
      chk1("out_rd_no_flags_obf", obf_n, 1'b1);
      step(1);
      cs_n = 1'b0; a = 2'b00; bus_in = 8'h55; wr_n = 1'b0;
      step(3);
      chk1("wr_fall_intr_clr", intr, 1'b0);
      wr_n = 1'b1;
      step(3);
      cs_n = 1'b1;
      chk8("wr2_pa_out", pa_out, 8'h55);
      chk1("wr2_obf_n", obf_n, 1'b0);
      step(1);
      ack_n = 1'b0;
      step(3);
      ack_n = 1'b1;
      step(3);
      // wr rise and ack fall land together: wr wins
      cs_n = 1'b0; a = 2'b00; bus_in = 8'h66; wr_n = 1'b0;
      step(3);
      wr_n = 1'b1; ack_n = 1'b0;
      step(3);
      cs_n = 1'b1;
      chk1("sim_obf_wr_wins", obf_n, 1'b0);
      chk8("sim_pa_out", pa_out, 8'h66);
      ack_n = 1'b1;
      step(3);
      chk1("ack_rise_obf_low_intr", intr, 1'b0);

      // Reset mid-operation
      reset = 1'b1;
      step(1);
      chk8("mid_rst_pa_out", pa_out, 8'h00);
      chk1("mid_rst_obf_n", obf_n, 1'b1);
      reset = 1'b0;
      step(4);
      peek("mid_rst_status", 2'b10, 8'h04, 1'b1);

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
